// File: rtl/fir_coeff_load_sequencer.sv
// FIR coefficient reload sequencer: loads taps into the coefficient RAM,
// flushes the sample delay line, then re-enables accumulation.
module fir_coeff_load_sequencer #(
   parameter int NUM_TAPS = 33,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 6
) (
   input  logic              iClk_12M,
   input  logic              iRsn,
   input  logic              iCoeffiUpdateFlag,
   input  logic              iCoeffValid,
   input  logic [DATA_W-1:0] iCoeffData,
   output logic              oCoeffReady,
   output logic              oCsnRam,
   output logic              oWrnRam,
   output logic [ADDR_W-1:0] oAddrRam,
   output logic [DATA_W-1:0] oWrDtRam,
   output logic              oEnDelay,
   output logic              oEnAcc,
   output logic              oBusy,
   output logic              oUpdateDone
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FLUSH,
      RUN
   } stateT;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TAPS - 1);

   stateT             state;
   stateT             stateNxt;
   logic [ADDR_W-1:0] tapCnt;
   logic [ADDR_W-1:0] tapCntNxt;
   logic [ADDR_W-1:0] flushCnt;
   logic [ADDR_W-1:0] flushCntNxt;
   logic              flagD;
   logic              rise;
   logic              accept;
   logic              lastTap;
   logic              lastFlush;
   logic              doneNxt;

   assign rise      = iCoeffiUpdateFlag & ~flagD;
   assign accept    = iCoeffValid & (state == LOAD);
   assign lastTap   = (tapCnt == LAST);
   assign lastFlush = (flushCnt == LAST);

   // State, counters, flag history and the registered done pulse
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         state       <= IDLE;
         tapCnt      <= '0;
         flushCnt    <= '0;
         flagD       <= 1'b0;
         oUpdateDone <= 1'b0;
      end else begin
         state       <= stateNxt;
         tapCnt      <= tapCntNxt;
         flushCnt    <= flushCntNxt;
         flagD       <= iCoeffiUpdateFlag;
         oUpdateDone <= doneNxt;
      end
   end

   // Next-state and counter update; last accept beats an abort
   always_comb begin
      stateNxt    = state;
      tapCntNxt   = tapCnt;
      flushCntNxt = flushCnt;
      doneNxt     = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise) begin
               stateNxt  = LOAD;
               tapCntNxt = '0;
            end
         end
         LOAD: begin
            if (accept && lastTap) begin
               stateNxt    = FLUSH;
               tapCntNxt   = '0;
               flushCntNxt = '0;
            end else if (!iCoeffiUpdateFlag) begin
               stateNxt  = IDLE;
               tapCntNxt = '0;
            end else if (accept) begin
               tapCntNxt = tapCnt + 1'b1;
            end
         end
         FLUSH: begin
            if (rise) begin
               stateNxt    = LOAD;
               tapCntNxt   = '0;
               flushCntNxt = '0;
            end else if (lastFlush) begin
               stateNxt    = RUN;
               flushCntNxt = '0;
               doneNxt     = 1'b1;
            end else begin
               flushCntNxt = flushCnt + 1'b1;
            end
         end
         RUN: begin
            if (rise) begin
               stateNxt  = LOAD;
               tapCntNxt = '0;
            end
         end
         default: begin
            stateNxt = IDLE;
         end
      endcase
   end

   // Registered RAM write port, one cycle behind each accept
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         oCsnRam  <= 1'b1;
         oWrnRam  <= 1'b1;
         oAddrRam <= '0;
         oWrDtRam <= '0;
      end else if (accept) begin
         oCsnRam  <= 1'b0;
         oWrnRam  <= 1'b0;
         oAddrRam <= tapCnt;
         oWrDtRam <= iCoeffData;
      end else begin
         oCsnRam  <= 1'b1;
         oWrnRam  <= 1'b1;
      end
   end

   assign oCoeffReady = (state == LOAD);
   assign oEnDelay    = (state == FLUSH) | (state == RUN);
   assign oEnAcc      = (state == RUN);
   assign oBusy       = (state == LOAD) | (state == FLUSH);

endmodule
